// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
// Contents:
//   state_e    - sequencer FSM states
//   SYNC_DEPTH - flop count of the request synchronizer
//   cnt_width  - counter width large enough for every delay parameter
package reset_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        STEP,
        WAIT_RDY,
        DONE
    } state_e;

    localparam int unsigned SYNC_DEPTH = 2;

    // Width that can represent the largest of the three delays.
    function automatic int unsigned cnt_width(input int unsigned hold_c,
                                              input int unsigned stagger_c,
                                              input int unsigned timeout_c);
        int unsigned m;
        m = hold_c;
        if (stagger_c > m) m = stagger_c;
        if (timeout_c > m) m = timeout_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Conduit bundle between software/stages and the reset sequencer.
// Ports:
//   coe_req     - software reset request (level, asynchronous)
//   coe_mask    - per-output select, latched at sequence start
//   stage_ready - per-stage ready flag after release
//   rst_out     - active-high stage resets
//   coe_busy    - sequence in progress
//   coe_done    - one-cycle completion pulse
//   coe_timeout - sticky: a stage missed its ready window
// master = requester/stage side, slave = sequencer side.
interface reset_sequencer_if #(
    parameter int unsigned N_OUT = 3
);
    logic             coe_req;
    logic [N_OUT-1:0] coe_mask;
    logic [N_OUT-1:0] stage_ready;
    logic [N_OUT-1:0] rst_out;
    logic             coe_busy;
    logic             coe_done;
    logic             coe_timeout;

    modport master (
        output coe_req, coe_mask, stage_ready,
        input  rst_out, coe_busy, coe_done, coe_timeout
    );

    modport slave (
        input  coe_req, coe_mask, stage_ready,
        output rst_out, coe_busy, coe_done, coe_timeout
    );
endinterface

// File: rtl/reset_sequencer_req_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for a slow level
// input from another clock domain (e.g. a PIO conduit).
// Ports:
//   clock      - destination clock
//   reset      - synchronous active-high reset, clears all flops
//   async_in   - asynchronous level input
//   rise_pulse - one-cycle pulse per rising edge of the synchronized level
module req_sync_edge
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEPTH = SYNC_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [DEPTH-1:0] sync_q, sync_d;
    logic             dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], async_in};
        dly_d  = sync_q[DEPTH-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    // Built only from flop outputs, so the pulse is glitch-free and lasts
    // exactly one cycle however long the input stays high.
    assign rise_pulse = sync_q[DEPTH-1] & ~dly_q;

endmodule

// File: rtl/reset_sequencer.sv
// Sequences active-high resets of up to N_OUT pipeline stages.
// Asserts the selected resets, holds them HOLD_CYCLES, then releases them
// in ascending index order, each STAGGER_CYCLES after its step starts, and
// waits up to TIMEOUT_CYCLES for that stage's ready flag. System reset
// runs the same sequence on every output.
// Ports:
//   clock - system clock
//   reset - synchronous active-high reset
//   io    - reset_sequencer_if.slave conduit bundle
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned N_OUT          = 3,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic               clock,
    input  logic               reset,
    reset_sequencer_if.slave   io
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

    logic req_edge;

    req_sync_edge #(
        .DEPTH (SYNC_DEPTH)
    ) u_req_sync (
        .clock      (clock),
        .reset      (reset),
        .async_in   (io.coe_req),
        .rise_pulse (req_edge)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_OUT-1:0] mask_q, mask_d;
    logic [N_OUT-1:0] rst_q, rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic             pend_q, pend_d;
    logic             adv;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        pend_d  = pend_q;
        adv     = 1'b0;

        // Edges while busy collapse into one pending request; DONE consumes
        // it (or a coincident edge) directly below.
        if (req_edge && state_q != IDLE) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    mask_d  = io.coe_mask;
                    rst_d   = io.coe_mask;
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = STEP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STEP: begin
                if (!mask_q[idx_q]) begin
                    adv = 1'b1;
                end else if (cnt_q == STAG_LAST) begin
                    rst_d[idx_q] = 1'b0;
                    cnt_d        = '0;
                    state_d      = WAIT_RDY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (io.stage_ready[idx_q]) begin
                    adv = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d = 1'b1;
                    adv   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (pend_q || req_edge) begin
                    pend_d  = 1'b0;
                    mask_d  = io.coe_mask;
                    rst_d   = io.coe_mask;
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rst_d   = '0;
            end
        endcase

        // Shared step advance: next index, or DONE after the last one.
        if (adv) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = STEP;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '1;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
        end
    end

    assign io.rst_out     = rst_q;
    assign io.coe_busy    = busy_q;
    assign io.coe_done    = done_q;
    assign io.coe_timeout = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (N_OUT=3, HOLD=4, STAGGER=2,
// TIMEOUT=8). Expected waveforms come from a schedule computed with plain
// arithmetic from the release rules.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int STAG = 2;
    localparam int TMO  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    reset_sequencer_if #(.N_OUT(N)) bif ();

    reset_sequencer #(
        .N_OUT          (N),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (bif)
    );

    int   checks = 0;
    int   errors = 0;
    logic prev_tmo = 1'b0;

    typedef struct packed {
        logic [2:0] rst;
        logic       busy;
        logic       done;
        logic       tmo;
    } obs_t;

    typedef struct {
        logic [2:0] mask;
        logic [2:0] ready;
        int         exp_done;
        logic       exp_tmo;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle index of the DONE cycle, counted from the cycle the resets
    // first show the latched mask (k=0).
    function automatic int seq_len(input logic [2:0] m, input logic [2:0] r);
        int b;
        b = HOLD;
        for (int i = 0; i < N; i++) begin
            if (m[i]) b = b + STAG + (r[i] ? 1 : TMO);
            else      b = b + 1;
        end
        return b;
    endfunction

    // Expected outputs k cycles into a sequence with constant ready flags.
    function automatic obs_t model(input int k, input logic [2:0] m, input logic [2:0] r);
        obs_t o;
        int   b;
        int   rel;
        o.rst = m;
        o.tmo = 1'b0;
        b     = HOLD;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                rel = b + STAG;
                if (k >= rel) o.rst[i] = 1'b0;
                b = r[i] ? rel + 1 : rel + TMO;
                if (!r[i] && k >= b) o.tmo = 1'b1;
            end else begin
                b = b + 1;
            end
        end
        o.done = (k == b);
        o.busy = (k <= b);
        return o;
    endfunction

    task automatic check_obs(input string tag, input obs_t e);
        chk({tag, ".rst_out"},     32'(bif.rst_out),     32'(e.rst));
        chk({tag, ".coe_busy"},    32'(bif.coe_busy),    32'(e.busy));
        chk({tag, ".coe_done"},    32'(bif.coe_done),    32'(e.done));
        chk({tag, ".coe_timeout"}, 32'(bif.coe_timeout), 32'(e.tmo));
    endtask

    // Caller is at the k=0 sample point. Optionally pulses coe_req at
    // req_at and drives coe_mask with next_mask or random values.
    task automatic follow_seq(input string tag, input logic [2:0] m, input logic [2:0] r,
                              input int last_k, input int req_at,
                              input logic [2:0] next_mask, input bit rand_mask,
                              output int done_k, output int ndone, output logic last_tmo);
        done_k   = -1;
        ndone    = 0;
        last_tmo = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) tick();
            check_obs(tag, model(k, m, r));
            if (bif.coe_done === 1'b1) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            last_tmo     = bif.coe_timeout;
            bif.coe_req  = (k == req_at);
            bif.coe_mask = rand_mask ? 3'($urandom) : next_mask;
        end
    endtask

    // Raises coe_req from IDLE; returns at the k=0 sample (third edge).
    task automatic do_request(input logic [2:0] m);
        obs_t idle;
        idle.rst  = '0;
        idle.busy = 1'b0;
        idle.done = 1'b0;
        idle.tmo  = prev_tmo;
        bif.coe_mask = m;
        bif.coe_req  = 1'b1;
        tick();
        check_obs("req_lat1", idle);
        tick();
        check_obs("req_lat2", idle);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        obs_t       rst_exp;
        int         dk, nd, dk2, nd2, dcount;
        logic       lt;
        logic [2:0] m, r;

        tbl[0] = '{mask: 3'b111, ready: 3'b111, exp_done: 13, exp_tmo: 1'b0};
        tbl[1] = '{mask: 3'b101, ready: 3'b111, exp_done: 11, exp_tmo: 1'b0};
        tbl[2] = '{mask: 3'b111, ready: 3'b101, exp_done: 20, exp_tmo: 1'b1};
        tbl[3] = '{mask: 3'b000, ready: 3'b000, exp_done: 7,  exp_tmo: 1'b0};
        tbl[4] = '{mask: 3'b010, ready: 3'b000, exp_done: 16, exp_tmo: 1'b1};
        tbl[5] = '{mask: 3'b100, ready: 3'b111, exp_done: 9,  exp_tmo: 1'b0};

        rst_exp.rst  = 3'b111;
        rst_exp.busy = 1'b1;
        rst_exp.done = 1'b0;
        rst_exp.tmo  = 1'b0;

        bif.coe_req     = 1'b0;
        bif.coe_mask    = 3'b000;
        bif.stage_ready = 3'b111;
        reset           = 1'b1;

        // Power-on: reset held five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_obs("por_reset", rst_exp);
        end
        reset = 1'b0;
        follow_seq("por", 3'b111, 3'b111, 15, -1, 3'b000, 1'b0, dk, nd, lt);
        chk("por_done_k", 32'(dk), 32'(13));
        chk("por_ndone", 32'(nd), 32'(1));
        prev_tmo = 1'b0;

        // Table of software-requested sequences.
        foreach (tbl[i]) begin
            bif.stage_ready = tbl[i].ready;
            do_request(tbl[i].mask);
            follow_seq("tbl", tbl[i].mask, tbl[i].ready, tbl[i].exp_done + 2, -1,
                       3'b000, 1'b1, dk, nd, lt);
            chk("tbl_done_k", 32'(dk), 32'(tbl[i].exp_done));
            chk("tbl_tmo_final", 32'(lt), 32'(tbl[i].exp_tmo));
            prev_tmo = tbl[i].exp_tmo;
        end

        // Request while busy: second edge during HOLD, new mask at DONE.
        bif.stage_ready = 3'b111;
        do_request(3'b011);
        follow_seq("pend1", 3'b011, 3'b111, seq_len(3'b011, 3'b111), 3, 3'b110, 1'b0,
                   dk, nd, lt);
        tick();
        follow_seq("pend2", 3'b110, 3'b111, seq_len(3'b110, 3'b111) + 2, -1, 3'b110, 1'b0,
                   dk2, nd2, lt);
        chk("pend_total_done", 32'(nd + nd2), 32'(2));
        prev_tmo = 1'b0;

        // Reset in WAIT_RDY of stage 1 with a pending request and a timeout.
        bif.stage_ready = 3'b000;
        do_request(3'b111);
        follow_seq("prerst", 3'b111, 3'b000, 17, 3, 3'b111, 1'b0, dk, nd, lt);
        chk("prerst_tmo_seen", 32'(lt), 32'(1));
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_obs("midrst", rst_exp);
        end
        reset           = 1'b0;
        bif.stage_ready = 3'b111;
        follow_seq("postrst", 3'b111, 3'b111, 15, -1, 3'b000, 1'b0, dk, nd, lt);
        chk("postrst_ndone", 32'(nd), 32'(1));
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bif.coe_busy !== 1'b0 || bif.coe_done !== 1'b0) dcount++;
        end
        chk("no_stale_pending", 32'(dcount), 32'(0));
        prev_tmo = 1'b0;

        // coe_req held high for 50 cycles yields one sequence.
        bif.coe_mask = 3'b111;
        bif.coe_req  = 1'b1;
        dcount = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bif.coe_done === 1'b1) dcount++;
        end
        bif.coe_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bif.coe_done === 1'b1) dcount++;
        end
        chk("held_req_ndone", 32'(dcount), 32'(1));
        chk("held_req_idle", 32'(bif.coe_busy), 32'(0));

        // Randomized masks, ready patterns and mid-sequence mask noise.
        for (int it = 0; it < 20; it++) begin
            m = 3'($urandom);
            r = 3'($urandom);
            bif.stage_ready = r;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            do_request(m);
            follow_seq("rand", m, r, seq_len(m, r) + 2, -1, 3'b000, 1'b1, dk, nd, lt);
            chk("rand_ndone", 32'(nd), 32'(1));
            prev_tmo = model(seq_len(m, r) + 2, m, r).tmo;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Controller that sequences the active-high resets of up to N_OUT signal-processing pipeline stages: ADC capture, filter, accumulator, FIFO.
- A software conduit from a Qsys PIO requests a reset. The block asserts the resets of the selected stages, holds them, then releases them in index order, waiting for each stage's ready flag.
- On system reset it runs the same release sequence on all stages automatically.

Parameters:
- N_OUT, 3, number of sequenced reset outputs (1..8)
- HOLD_CYCLES, 16, cycles all selected resets stay asserted (>=1)
- STAGGER_CYCLES, 4, cycles between start of a release step and deassertion of that output (>=1)
- TIMEOUT_CYCLES, 256, maximum cycles to wait for stage_ready after a release (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- coe_req  in  1  software reset request (level, asynchronous to clock, PIO conduit)
- coe_mask  in  N_OUT  per-output select; 1 = include in sequence; latched at sequence start
- stage_ready  in  N_OUT  per-stage ready indication after its reset is released
- rst_out  out  N_OUT  active-high resets to stages
- coe_busy  out  1  high while a sequence is in progress
- coe_done  out  1  one-cycle pulse on sequence completion
- coe_timeout  out  1  sticky: some stage failed to report ready in the last sequence

Behaviour:
- The clock is named clock. Reset is synchronous and active-high, named reset.
- Values while reset is high:
  - rst_out = all ones, coe_busy = 1, coe_done = 0, coe_timeout = 0
  - pending cleared, synchronizer flops cleared
  - mask_q = all ones, FSM forced to HOLD with counter cleared
- On the first cycle after reset falls, the power-on sequence proceeds from HOLD.
- Request path:
  - coe_req passes a 2-flop synchronizer; a rising-edge detect compares the sync output with its delayed copy.
  - From IDLE, rst_out rises on the 3rd rising clock edge after coe_req is first sampled high.
  - A held-high coe_req produces exactly one edge.
- FSM states: IDLE, HOLD, STEP, WAIT_RDY, DONE.
  - IDLE: coe_busy = 0, rst_out = 0. On a request edge: mask_q <= coe_mask, rst_out <= coe_mask, coe_timeout <= 0, cnt <= 0, coe_busy <= 1, go to HOLD.
  - HOLD: rst_out = mask_q for exactly HOLD_CYCLES cycles, then idx <= 0, cnt <= 0, go to STEP.
  - STEP:
    - If mask_q[idx] = 0, skip in one cycle: advance idx, or go to DONE if idx = N_OUT-1.
    - Otherwise count STAGGER_CYCLES, then rst_out[idx] <= 0, cnt <= 0, go to WAIT_RDY.
  - WAIT_RDY:
    - If stage_ready[idx] = 1, advance.
    - Else if cnt = TIMEOUT_CYCLES-1, coe_timeout <= 1 and advance.
    - Advance means idx+1 and back to STEP, or DONE after the last index.
  - DONE: coe_done = 1 for one cycle.
    - If pending = 1: clear pending, relatch coe_mask, start a new HOLD (busy stays high).
    - Else go to IDLE; coe_busy falls the next cycle.
- Release order and timing:
  - Outputs release strictly in ascending index order.
  - Deasserted outputs never reassert within a sequence.
  - Unselected outputs stay 0 throughout the sequence.
- Request edge while busy (any state other than IDLE) sets pending. Multiple edges collapse into one.
- An edge coincident with DONE also sets pending and is serviced immediately.
- Changes to coe_mask mid-sequence have no effect.
- Reset mid-operation: all rst_out reassert on the next edge, pending and timeout are cleared, and the power-on sequence restarts.
- Widths:
  - cnt width = $clog2(max(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES)+1)
  - idx width = max(1, $clog2(N_OUT))
  - No counter wraps; all compares are equality against the parameter minus 1.
- coe_mask = 0 request: HOLD runs with all outputs at 0, every index skips, coe_done pulses.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum (IDLE, HOLD, STEP, WAIT_RDY, DONE)
  - cnt_width function
  - localparam for synchronizer depth = 2
- One sub-module: req_sync_edge, a 2-flop synchronizer plus registered rising-edge pulse. It is also reusable for other PIO conduits.

Test Plan (N_OUT=3, HOLD=4, STAGGER=2, TIMEOUT=8 unless noted):
- Power-on, stage_ready=3'b111: reset high 5 cycles, then low.
  - rst_out=111 during reset and 4 cycles after.
  - rst_out[0] falls 2 cycles later; bits 1 and 2 follow at 3-cycle intervals (2 stagger + 1 wait).
  - coe_done pulses once, coe_busy falls.
- Software request, coe_mask=3'b101, ready tied high.
  - rst_out goes to 101 on the 3rd edge after coe_req rises; rst_out[1] stays 0 throughout.
  - Bits 0 and 2 release in order; a single done pulse follows.
- Timeout: stage_ready[1]=0.
  - Bit 1 releases, 8 cycles elapse, coe_timeout=1, sequence continues, done pulses.
  - The next request clears coe_timeout on its first cycle.
- Request while busy: second coe_req edge during HOLD.
  - Immediately after done, rst_out reasserts to the newly latched mask.
  - coe_busy stays high across both sequences; two done pulses total.
- Reset mid-WAIT_RDY with pending set.
  - Next edge: rst_out=111, coe_timeout=0.
  - After reset, one full 111 sequence runs; no extra sequence from the stale pending.
- coe_req held high 50 cycles, then low: exactly one sequence and one coe_done pulse.
